// File: rtl/smem_sprite_writer.sv
// Screen-memory sprite writer: moves one sprite charcode across a wrapped character grid,
// erasing the vacated cell and drawing the new one on every movement step.
module smem_sprite_writer #(
    parameter int Nchars          = 4,
    parameter int smem_size       = 1200,
    parameter int Ncols           = 40,
    parameter int Nrows           = 30,
    parameter int bg_code         = 0,
    parameter int sprite_code     = 1,
    parameter int frames_per_step = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         vsync,
    input  logic                         enable,
    input  logic [3:0]                   btn,
    output logic                         wr_en,
    output logic [$clog2(smem_size)-1:0] wr_addr,
    output logic [$clog2(Nchars)-1:0]    wr_data,
    output logic [$clog2(Ncols)-1:0]     sprite_x,
    output logic [$clog2(Nrows)-1:0]     sprite_y,
    output logic                         busy
);

    localparam int AW = $clog2(smem_size);
    localparam int DW = $clog2(Nchars);
    localparam int XW = $clog2(Ncols);
    localparam int YW = $clog2(Nrows);
    localparam int FW = (frames_per_step > 1) ? $clog2(frames_per_step) : 1;

    localparam logic [XW-1:0] x_max     = XW'(Ncols - 1);
    localparam logic [YW-1:0] y_max     = YW'(Nrows - 1);
    localparam logic [FW-1:0] fcnt_last = FW'(frames_per_step - 1);
    localparam logic [DW-1:0] bg_val    = DW'(bg_code);
    localparam logic [DW-1:0] sprite_val = DW'(sprite_code);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        ERASE = 2'd2,
        DRAW  = 2'd3
    } state_t;

    state_t          state_r;
    logic [XW-1:0]   x_r, nx_r, nx_s;
    logic [YW-1:0]   y_r, ny_r, ny_s;
    logic [FW-1:0]   fcnt_r;
    logic            vs_q_r;
    logic            wr_en_r, busy_r;
    logic [AW-1:0]   wr_addr_r;
    logic [DW-1:0]   wr_data_r;
    logic            tick_s, due_s, step_s;

    function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(y) * AW'(Ncols) + AW'(x);
    endfunction

    // Frame tick on the falling edge of vsync, and whether a movement step fires on it.
    always_comb begin
        tick_s = vs_q_r & ~vsync;
        due_s  = tick_s & (fcnt_r == fcnt_last);
        step_s = due_s & enable & (|btn);
    end

    // Next sprite position with wrap-around; up beats down beats left beats right.
    always_comb begin
        nx_s = x_r;
        ny_s = y_r;
        if (btn[3]) begin
            ny_s = (y_r == {YW{1'b0}}) ? y_max : y_r - YW'(1);
        end else if (btn[2]) begin
            ny_s = (y_r == y_max) ? {YW{1'b0}} : y_r + YW'(1);
        end else if (btn[1]) begin
            nx_s = (x_r == {XW{1'b0}}) ? x_max : x_r - XW'(1);
        end else if (btn[0]) begin
            nx_s = (x_r == x_max) ? {XW{1'b0}} : x_r + XW'(1);
        end else begin
            nx_s = x_r;
            ny_s = y_r;
        end
    end

    // Frame counter, write FSM and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= INIT;
            x_r       <= {XW{1'b0}};
            y_r       <= {YW{1'b0}};
            nx_r      <= {XW{1'b0}};
            ny_r      <= {YW{1'b0}};
            fcnt_r    <= {FW{1'b0}};
            vs_q_r    <= 1'b1;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= {DW{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            vs_q_r <= vsync;
            if (tick_s) begin
                fcnt_r <= due_s ? {FW{1'b0}} : fcnt_r + FW'(1);
            end
            // Outputs are loaded on the edge that enters the state they belong to.
            case (state_r)
                INIT: begin
                    state_r   <= IDLE;
                    wr_en_r   <= 1'b1;
                    wr_addr_r <= addr_of(x_r, y_r);
                    wr_data_r <= sprite_val;
                    busy_r    <= 1'b0;
                end
                IDLE: begin
                    if (step_s) begin
                        state_r   <= ERASE;
                        nx_r      <= nx_s;
                        ny_r      <= ny_s;
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= addr_of(x_r, y_r);
                        wr_data_r <= bg_val;
                        busy_r    <= 1'b1;
                    end else begin
                        wr_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ERASE: begin
                    state_r   <= DRAW;
                    wr_en_r   <= 1'b1;
                    wr_addr_r <= addr_of(nx_r, ny_r);
                    wr_data_r <= sprite_val;
                    busy_r    <= 1'b1;
                end
                DRAW: begin
                    state_r <= IDLE;
                    x_r     <= nx_r;
                    y_r     <= ny_r;
                    wr_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= INIT;
                    wr_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = busy_r;
    assign sprite_x = x_r;
    assign sprite_y = y_r;

endmodule

// File: tb/tb_smem_sprite_writer.sv
// Scoreboard bench for smem_sprite_writer: a grid-level model predicts every write,
// a negedge monitor compares each observed write against the queue.
module tb_smem_sprite_writer;

    localparam int NC  = 40;
    localparam int NR  = 30;
    localparam int FPS = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic        enable;
    logic [3:0]  btn;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [1:0]  wr_data;
    logic [5:0]  sprite_x;
    logic [4:0]  sprite_y;
    logic        busy;

    typedef struct {
        int addr;
        int data;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mx = 0, my = 0, fc = 0;

    smem_sprite_writer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vsync    (vsync),
        .enable   (enable),
        .btn      (btn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .sprite_x (sprite_x),
        .sprite_y (sprite_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int addr, input int data, input int bsy);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.busy = bsy;
        exp_q.push_back(e);
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(wr_addr), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
                check("busy_on_write", int'(busy), e.busy);
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        vsync   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_busy", int'(busy), 0);
        mx = 0; my = 0; fc = 0;
        push(0, 1, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One vsync frame; abort asserts reset one cycle after the tick (during ERASE).
    task automatic frame(input logic [3:0] b, input logic en, input bit abort);
        int nxm, nym;
        btn    = b;
        enable = en;
        @(posedge clk);
        #1 vsync = 1'b0;
        fc = (fc + 1) % FPS;
        if (fc == 0 && en && b != 4'b0000) begin
            nxm = mx; nym = my;
            if (b[3])      nym = (my + NR - 1) % NR;
            else if (b[2]) nym = (my + 1) % NR;
            else if (b[1]) nxm = (mx + NC - 1) % NC;
            else           nxm = (mx + 1) % NC;
            push(my * NC + mx, 0, 1);
            if (!abort) begin
                push(nym * NC + nxm, 1, 1);
                mx = nxm; my = nym;
            end
        end
        if (abort) begin
            @(posedge clk);
            #1 reset_n = 1'b0;
            vsync = 1'b1;
            btn   = 4'b0000;
            do_reset();
        end else begin
            repeat (3) @(posedge clk);
            #1 vsync = 1'b1;
            btn = 4'b1111;
            repeat (4) @(posedge clk);
            #1;
            check("sprite_x", int'(sprite_x), mx);
            check("sprite_y", int'(sprite_y), my);
        end
    endtask

    task automatic step(input logic [3:0] b, input logic en);
        for (int i = 0; i < FPS; i++) frame(b, en, 1'b0);
    endtask

    initial begin
        int budget;
        btn    = 4'b0000;
        enable = 1'b1;
        do_reset();
        check("idle_busy", int'(busy), 0);
        // right: (0,0)->(1,0), then left twice through the x=0 wrap
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        // back to x=0 then right to x=5, then up through the y=0 wrap
        step(4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b1);
        step(4'b1000, 1'b1);
        // down through the y=29 wrap, then up+right priority, then enable low on a due tick
        step(4'b0100, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b0110, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b1);
        // randomized frames
        for (int i = 0; i < 48; i++) begin
            frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        // reset during ERASE: draw must never appear, INIT write follows release
        for (int i = 0; i < FPS - 1; i++) frame(4'b0001, 1'b1, 1'b0);
        frame(4'b0001, 1'b1, 1'b1);
        check("abort_x", int'(sprite_x), 0);
        step(4'b0100, 1'b1);
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
